parking_space_allocator: RTL and testbench

Sequential manager for an 8-space lot that produces the per-space free vector consumed by the lot's capacity counter. It assigns the lowest-numbered free space to each arriving car through an entry-gate handshake. It releases spaces on exit requests, returns a space when a granted car never passes the gate, and keeps registered free/parked counts consistent with the vector every cycle.

---
 rtl/parking_space_allocator_if.sv | 34 +++
 rtl/parking_space_allocator.sv | 134 +++++++++++++
 tb/tb_parking_space_allocator.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/parking_space_allocator_if.sv
// Entry/exit handshake and occupancy bus of the parking space allocator.
// slave = allocator side, master = gate controller / environment side.
interface parking_space_allocator_if;
    logic       entry_req;
    logic       entry_done;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic       entry_ack;
    logic [2:0] entry_slot;
    logic       entry_deny;
    logic       entry_abort;
    logic       gate_open;
    logic       exit_ack;
    logic       exit_err;
    logic [7:0] space_free;
    logic [3:0] free_count;
    logic [3:0] parked_count;
    logic       full;
    logic       lot_empty;

    modport slave (
        input  entry_req, entry_done, exit_req, exit_slot,
        output entry_ack, entry_slot, entry_deny, entry_abort, gate_open,
               exit_ack, exit_err, space_free, free_count, parked_count,
               full, lot_empty
    );

    modport master (
        output entry_req, entry_done, exit_req, exit_slot,
        input  entry_ack, entry_slot, entry_deny, entry_abort, gate_open,
               exit_ack, exit_err, space_free, free_count, parked_count,
               full, lot_empty
    );
endinterface

// File: rtl/parking_space_allocator.sv
// 8-space lot allocator: lowest-free grant through a gate handshake with timeout,
// independent exit path, and registered free/parked counts tracking the vector.
module parking_space_allocator #(
    parameter int GATE_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    parking_space_allocator_if.slave    bus
);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] GATE_OPEN    = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;

    logic [1:0] state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] free_nxt;
    logic [2:0] slot_nxt;
    logic [3:0] free_cnt_nxt;
    logic       ack_nxt, deny_nxt, abort_nxt, xack_nxt, xerr_nxt;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        free_nxt  = bus.space_free;
        slot_nxt  = bus.entry_slot;
        ack_nxt   = 1'b0;
        deny_nxt  = 1'b0;
        abort_nxt = 1'b0;
        xack_nxt  = 1'b0;
        xerr_nxt  = 1'b0;

        // The space held at an open gate is not yet parked, so it cannot exit.
        if (bus.exit_req) begin
            if (!bus.space_free[bus.exit_slot] &&
                !(state == GATE_OPEN && bus.exit_slot == bus.entry_slot)) begin
                free_nxt[bus.exit_slot] = 1'b1;
                xack_nxt = 1'b1;
            end else begin
                xerr_nxt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (bus.entry_req) begin
                    if (|bus.space_free) begin
                        free_nxt[lowest_set(bus.space_free)] = 1'b0;
                        slot_nxt  = lowest_set(bus.space_free);
                        ack_nxt   = 1'b1;
                        cnt_nxt   = 8'd0;
                        state_nxt = GATE_OPEN;
                    end else begin
                        deny_nxt  = 1'b1;
                        state_nxt = WAIT_RELEASE;
                    end
                end
            end
            GATE_OPEN: begin
                cnt_nxt = cnt + 8'd1;
                // entry_done takes priority over a timeout on the same edge.
                if (bus.entry_done) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = WAIT_RELEASE;
                end else if (cnt_nxt == 8'(GATE_TIMEOUT)) begin
                    free_nxt[bus.entry_slot] = 1'b1;
                    abort_nxt = 1'b1;
                    cnt_nxt   = 8'd0;
                    state_nxt = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!bus.entry_req) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = 8'd0;
                state_nxt = IDLE;
            end
        endcase

        free_cnt_nxt = popcount(free_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= 8'd0;
            bus.space_free   <= 8'hFF;
            bus.free_count   <= 4'd8;
            bus.parked_count <= 4'd0;
            bus.full         <= 1'b0;
            bus.lot_empty    <= 1'b1;
            bus.entry_slot   <= 3'd0;
            bus.entry_ack    <= 1'b0;
            bus.entry_deny   <= 1'b0;
            bus.entry_abort  <= 1'b0;
            bus.exit_ack     <= 1'b0;
            bus.exit_err     <= 1'b0;
            bus.gate_open    <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            bus.space_free   <= free_nxt;
            bus.free_count   <= free_cnt_nxt;
            bus.parked_count <= 4'd8 - free_cnt_nxt;
            bus.full         <= (free_nxt == 8'h00);
            bus.lot_empty    <= (free_nxt == 8'hFF);
            bus.entry_slot   <= slot_nxt;
            bus.entry_ack    <= ack_nxt;
            bus.entry_deny   <= deny_nxt;
            bus.entry_abort  <= abort_nxt;
            bus.exit_ack     <= xack_nxt;
            bus.exit_err     <= xerr_nxt;
            bus.gate_open    <= (state_nxt == GATE_OPEN);
        end
    end
endmodule

// File: tb/tb_parking_space_allocator.sv
// Self-checking bench for parking_space_allocator: vector table, directed corner
// sequences and randomized traffic against an occupancy-level reference model.
module tb_parking_space_allocator;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    parking_space_allocator_if bus ();

    parking_space_allocator #(.GATE_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    // Reference model: which spaces hold a car, which space waits at the gate.
    bit occ [8];
    int pend;
    int elapsed;
    bit waiting;
    bit m_ack, m_deny, m_abort, m_xack, m_xerr;
    int m_slot;

    typedef struct {
        bit         rst, req, done, xreq;
        logic [2:0] xslot;
        bit         ack, xack, xerr, gate;
        logic [2:0] slot;
        logic [7:0] free;
        int         fcnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_free();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = ~occ[i];
        return v;
    endfunction

    function automatic int m_fcnt();
        int n = 0;
        for (int i = 0; i < 8; i++) if (!occ[i]) n++;
        return n;
    endfunction

    task automatic model_step(input bit r, input bit rq, input bit dn, input bit xr, input int xs);
        bit old_occ [8];
        int old_pend;
        int found;
        m_ack = 0; m_deny = 0; m_abort = 0; m_xack = 0; m_xerr = 0;
        if (r) begin
            for (int i = 0; i < 8; i++) occ[i] = 0;
            pend = -1; elapsed = 0; waiting = 0; m_slot = 0;
            return;
        end
        old_occ = occ;
        old_pend = pend;
        if (xr) begin
            if (old_occ[xs] && xs != old_pend) begin
                occ[xs] = 0; m_xack = 1;
            end else begin
                m_xerr = 1;
            end
        end
        if (pend >= 0) begin
            elapsed++;
            if (dn) begin
                pend = -1; waiting = 1;
            end else if (elapsed == TO) begin
                occ[pend] = 0; m_abort = 1; pend = -1; waiting = 1;
            end
        end else if (waiting) begin
            if (!rq) waiting = 0;
        end else if (rq) begin
            found = -1;
            for (int i = 7; i >= 0; i--) if (!old_occ[i]) found = i;
            if (found >= 0) begin
                occ[found] = 1; pend = found; m_slot = found; elapsed = 0; m_ack = 1;
            end else begin
                m_deny = 1; waiting = 1;
            end
        end
    endtask

    task automatic check_model();
        chk("ack",    32'(bus.entry_ack),    32'(m_ack));
        chk("deny",   32'(bus.entry_deny),   32'(m_deny));
        chk("abort",  32'(bus.entry_abort),  32'(m_abort));
        chk("xack",   32'(bus.exit_ack),     32'(m_xack));
        chk("xerr",   32'(bus.exit_err),     32'(m_xerr));
        chk("gate",   32'(bus.gate_open),    32'(pend >= 0));
        chk("slot",   32'(bus.entry_slot),   32'(m_slot));
        chk("free",   32'(bus.space_free),   32'(m_free()));
        chk("fcnt",   32'(bus.free_count),   32'(m_fcnt()));
        chk("pcnt",   32'(bus.parked_count), 32'(8 - m_fcnt()));
        chk("full",   32'(bus.full),         32'(m_fcnt() == 0));
        chk("empty",  32'(bus.lot_empty),    32'(m_fcnt() == 8));
        chk("sum",    32'(bus.free_count) + 32'(bus.parked_count), 32'd8);
    endtask

    task automatic cycle(input bit r, input bit rq, input bit dn, input bit xr, input logic [2:0] xs);
        rst = r; bus.entry_req = rq; bus.entry_done = dn; bus.exit_req = xr; bus.exit_slot = xs;
        @(posedge clk);
        model_step(r, rq, dn, xr, int'(xs));
        #1;
        check_model();
    endtask

    task automatic enter_and_park(input int exp_slot);
        cycle(0, 1, 0, 0, 3'd0);
        chk("park_ack", 32'(bus.entry_ack), 32'd1);
        chk("park_slot", 32'(bus.entry_slot), 32'(exp_slot));
        cycle(0, 0, 1, 0, 3'd0);
        cycle(0, 0, 0, 0, 3'd0);
    endtask

    vec_t tbl [12];
    bit   rq_r;

    initial begin
        rst = 1'b1;
        bus.entry_req = 0; bus.entry_done = 0; bus.exit_req = 0; bus.exit_slot = 3'd0;
        pend = -1; elapsed = 0; waiting = 0; m_slot = 0;

        //           rst req dn xr xs     ack xa xe gt slot  free   fc
        tbl[0]  = '{1, 0, 0, 0, 3'd0,  0, 0, 0, 0, 3'd0, 8'hFF, 8};
        tbl[1]  = '{0, 1, 0, 0, 3'd0,  1, 0, 0, 1, 3'd0, 8'hFE, 7};
        tbl[2]  = '{0, 0, 0, 0, 3'd0,  0, 0, 0, 1, 3'd0, 8'hFE, 7};
        tbl[3]  = '{0, 0, 0, 0, 3'd0,  0, 0, 0, 1, 3'd0, 8'hFE, 7};
        tbl[4]  = '{0, 0, 1, 0, 3'd0,  0, 0, 0, 0, 3'd0, 8'hFE, 7};
        tbl[5]  = '{0, 0, 1, 0, 3'd0,  0, 0, 0, 0, 3'd0, 8'hFE, 7};
        tbl[6]  = '{0, 1, 0, 0, 3'd0,  1, 0, 0, 1, 3'd1, 8'hFC, 6};
        tbl[7]  = '{0, 0, 0, 1, 3'd1,  0, 0, 1, 1, 3'd1, 8'hFC, 6};
        tbl[8]  = '{0, 0, 0, 1, 3'd0,  0, 1, 0, 1, 3'd1, 8'hFD, 7};
        tbl[9]  = '{0, 0, 1, 0, 3'd0,  0, 0, 0, 0, 3'd1, 8'hFD, 7};
        tbl[10] = '{0, 0, 0, 1, 3'd1,  0, 1, 0, 0, 3'd1, 8'hFF, 8};
        tbl[11] = '{0, 0, 0, 1, 3'd3,  0, 0, 1, 0, 3'd1, 8'hFF, 8};

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].xreq, tbl[i].xslot);
            chk($sformatf("tbl%0d_ack", i),  32'(bus.entry_ack),    32'(tbl[i].ack));
            chk($sformatf("tbl%0d_xack", i), 32'(bus.exit_ack),     32'(tbl[i].xack));
            chk($sformatf("tbl%0d_xerr", i), 32'(bus.exit_err),     32'(tbl[i].xerr));
            chk($sformatf("tbl%0d_gate", i), 32'(bus.gate_open),    32'(tbl[i].gate));
            chk($sformatf("tbl%0d_slot", i), 32'(bus.entry_slot),   32'(tbl[i].slot));
            chk($sformatf("tbl%0d_free", i), 32'(bus.space_free),   32'(tbl[i].free));
            chk($sformatf("tbl%0d_fcnt", i), 32'(bus.free_count),   32'(tbl[i].fcnt));
            chk($sformatf("tbl%0d_pcnt", i), 32'(bus.parked_count), 32'(8 - tbl[i].fcnt));
        end

        // Fill the lot, then a ninth car is denied.
        cycle(1, 0, 0, 0, 3'd0);
        for (int k = 0; k < 8; k++) enter_and_park(k);
        chk("fill_free", 32'(bus.space_free), 32'h00);
        chk("fill_full", 32'(bus.full), 32'd1);
        cycle(0, 1, 0, 0, 3'd0);
        chk("deny_pulse", 32'(bus.entry_deny), 32'd1);
        chk("deny_free", 32'(bus.space_free), 32'h00);
        cycle(0, 1, 0, 0, 3'd0);
        chk("deny_once", 32'(bus.entry_deny), 32'd0);
        cycle(0, 0, 0, 0, 3'd0);

        // Free space 5 from a full lot; it is the next grant.
        cycle(0, 0, 0, 1, 3'd5);
        chk("x5_ack", 32'(bus.exit_ack), 32'd1);
        chk("x5_free", 32'(bus.space_free), 32'h20);
        enter_and_park(5);

        // Gate timeout, exit of the pending space rejected.
        cycle(1, 0, 0, 0, 3'd0);
        cycle(0, 1, 0, 0, 3'd0);
        chk("to_ack", 32'(bus.entry_ack), 32'd1);
        for (int k = 1; k <= TO; k++) begin
            cycle(0, 0, 0, k == 1, 3'd0);
            if (k == 1) chk("to_xerr", 32'(bus.exit_err), 32'd1);
            chk($sformatf("to_abort_%0d", k), 32'(bus.entry_abort), 32'(k == TO));
            chk($sformatf("to_gate_%0d", k), 32'(bus.gate_open), 32'(k != TO));
        end
        chk("to_free", 32'(bus.space_free), 32'hFF);
        cycle(0, 0, 0, 0, 3'd0);

        // entry_done on the timeout edge wins.
        cycle(0, 1, 0, 0, 3'd0);
        for (int k = 1; k <= TO; k++) cycle(0, 0, k == TO, 0, 3'd0);
        chk("dw_abort", 32'(bus.entry_abort), 32'd0);
        chk("dw_gate", 32'(bus.gate_open), 32'd0);
        chk("dw_free", 32'(bus.space_free), 32'hFE);
        cycle(0, 0, 0, 0, 3'd0);

        // Grant and exit on the same edge.
        enter_and_park(1);
        cycle(0, 1, 0, 1, 3'd1);
        chk("se_slot", 32'(bus.entry_slot), 32'd2);
        chk("se_xack", 32'(bus.exit_ack), 32'd1);
        chk("se_free", 32'(bus.space_free), 32'hFA);
        chk("se_fcnt", 32'(bus.free_count), 32'd6);
        cycle(0, 0, 1, 0, 3'd0);
        cycle(0, 0, 0, 0, 3'd0);

        // Reset mid-gate with three spaces occupied.
        cycle(0, 1, 0, 0, 3'd0);
        chk("rg_slot", 32'(bus.entry_slot), 32'd1);
        chk("rg_parked", 32'(bus.parked_count), 32'd3);
        cycle(1, 1, 0, 0, 3'd0);
        chk("rg_free", 32'(bus.space_free), 32'hFF);
        chk("rg_gate", 32'(bus.gate_open), 32'd0);
        chk("rg_ack", 32'(bus.entry_ack), 32'd0);
        chk("rg_fcnt", 32'(bus.free_count), 32'd8);
        chk("rg_pcnt", 32'(bus.parked_count), 32'd0);
        cycle(0, 1, 0, 0, 3'd0);
        chk("rg_idle_ack", 32'(bus.entry_ack), 32'd1);
        chk("rg_idle_slot", 32'(bus.entry_slot), 32'd0);

        // Randomized traffic against the model.
        rq_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 4) == 0) rq_r = ~rq_r;
            cycle($urandom_range(0, 199) == 0, rq_r, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
